// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered 8N1 UART transmitter: FSM encoding,
// frame constants and the divider floor.
package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int DIV_MIN   = 4;
  localparam int DATA_BITS = 8;

  // Dividers below DIV_MIN are raised to it so a bit always spans DIV_MIN clocks.
  function automatic logic [31:0] clamp_div(input logic [31:0] v);
    return (v < 32'(DIV_MIN)) ? 32'(DIV_MIN) : v;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO. A push while full is accepted only when a pop
// happens in the same cycle; the count register is kept apart from the pointers.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= din;
  end

  assign dout  = r_mem[r_rptr];
  assign count = r_count;
  assign full  = (r_count == (AW+1)'(DEPTH));
  assign empty = (r_count == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes queue in a FIFO and are serialised LSB
// first; each frame is 10 bits of bit_div clocks, bit_div latched at the pop.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int DIV_RESET  = 87,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 data_write,
  input  logic [7:0]           data_in,
  input  logic                 div_write,
  input  logic [DIV_WIDTH-1:0] div_in,
  input  logic                 clear_ovf,
  output logic                 tx,
  output logic                 busy,
  output logic [CW-1:0]        fifo_count,
  output logic                 fifo_full,
  output logic                 overflow
);

  // data_write, div_write and clear_ovf are single-cycle strobes with no
  // back-pressure: a strobe acts on the clock edge where it is high, exactly once.
  tx_state_e            r_state;
  logic                 r_tx;
  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] r_bit_div;
  logic [DIV_WIDTH-1:0] r_timer;
  logic [2:0]           r_bit_cnt;
  logic [7:0]           r_shift;
  logic                 r_ovf;
  logic [7:0]           w_fifo_dout;
  logic [CW-1:0]        w_count;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic                 w_ovf_set;

  // Pop from IDLE, or on the final stop-bit clock so frames run back to back.
  assign w_pop = !w_empty &&
                 ((r_state == ST_IDLE) || ((r_state == ST_STOP) && (r_timer == '0)));
  assign w_ovf_set = data_write && w_full && !w_pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (data_write),
    .din     (data_in),
    .pop     (w_pop),
    .dout    (w_fifo_dout),
    .count   (w_count),
    .full    (w_full),
    .empty   (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_div <= DIV_WIDTH'(DIV_RESET);
    end else if (div_write) begin
      r_div <= DIV_WIDTH'(clamp_div(32'(div_in)));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (clear_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_tx      <= 1'b1;
      r_bit_div <= DIV_WIDTH'(DIV_RESET);
      r_timer   <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (w_pop) begin
      r_state   <= ST_START;
      r_tx      <= 1'b0;
      r_shift   <= w_fifo_dout;
      r_bit_div <= r_div;
      r_timer   <= r_div - DIV_WIDTH'(1);
    end else if (r_timer != '0) begin
      r_timer <= r_timer - DIV_WIDTH'(1);
    end else begin
      case (r_state)
        ST_START: begin
          r_state   <= ST_DATA;
          r_tx      <= r_shift[0];
          r_shift   <= r_shift >> 1;
          r_bit_cnt <= '0;
          r_timer   <= r_bit_div - DIV_WIDTH'(1);
        end
        ST_DATA: begin
          r_timer <= r_bit_div - DIV_WIDTH'(1);
          if (r_bit_cnt == 3'(DATA_BITS - 1)) begin
            r_state <= ST_STOP;
            r_tx    <= 1'b1;
          end else begin
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
        end
        ST_STOP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx         = r_tx;
  assign busy       = (r_state != ST_IDLE) || (w_count != '0);
  assign fifo_count = w_count;
  assign fifo_full  = w_full;
  assign overflow   = r_ovf;

endmodule
